cbus_arbiter: RTL

- Shares the single cache-bus (CBus) master port to the CBus-to-AXI converter among NUM_REQ requesters (default: port 0 = data side, port 1 = instruction fetch).
- Selects one requester, locks the grant for the whole transaction including burst beats, and routes responses back to the owner only.
- Sits between the core's fetch/memory stages (or their caches) and the bus converter.

---
 rtl/cbus_arbiter_if.sv | 45 ++++
 rtl/cbus_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/cbus_arbiter_if.sv
// CBus arbiter bundle: per-requester request/response lanes (flattened, lane i at [i*W +: W])
// plus the single downstream master port. Modport master = arbiter view, slave = environment view.
interface cbus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        ireq_valid;
  logic [NUM_REQ-1:0]        ireq_is_write;
  logic [3*NUM_REQ-1:0]      ireq_size;
  logic [ADDR_W*NUM_REQ-1:0] ireq_addr;
  logic [STRB_W*NUM_REQ-1:0] ireq_strobe;
  logic [DATA_W*NUM_REQ-1:0] ireq_data;
  logic [4*NUM_REQ-1:0]      ireq_len;
  logic [NUM_REQ-1:0]        iresp_ready;
  logic [NUM_REQ-1:0]        iresp_last;
  logic [DATA_W*NUM_REQ-1:0] iresp_data;

  logic              oreq_valid;
  logic              oreq_is_write;
  logic [2:0]        oreq_size;
  logic [ADDR_W-1:0] oreq_addr;
  logic [STRB_W-1:0] oreq_strobe;
  logic [DATA_W-1:0] oreq_data;
  logic [3:0]        oreq_len;
  logic              oresp_ready;
  logic              oresp_last;
  logic [DATA_W-1:0] oresp_data;

  modport master (
    input  ireq_valid, ireq_is_write, ireq_size, ireq_addr, ireq_strobe, ireq_data, ireq_len,
    output iresp_ready, iresp_last, iresp_data,
    output oreq_valid, oreq_is_write, oreq_size, oreq_addr, oreq_strobe, oreq_data, oreq_len,
    input  oresp_ready, oresp_last, oresp_data
  );

  modport slave (
    output ireq_valid, ireq_is_write, ireq_size, ireq_addr, ireq_strobe, ireq_data, ireq_len,
    input  iresp_ready, iresp_last, iresp_data,
    input  oreq_valid, oreq_is_write, oreq_size, oreq_addr, oreq_strobe, oreq_data, oreq_len,
    output oresp_ready, oresp_last, oresp_data
  );
endinterface

// File: rtl/cbus_arbiter.sv
// Shares one CBus master among NUM_REQ requesters; 1-cycle arbitration, grant locked until the last beat.
// Fixed priority (lowest index) by default; CBUS_ARBITER_ROUND_ROBIN_EN selects round-robin.
module cbus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  cbus_arbiter_if.master     bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   win_idx;

`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic [SEL_W-1:0]   cand;
  logic               win_found;

  // Search starts at rr_q and wraps, so the port after the last winner gets first look.
  always_comb begin
    win_idx   = '0;
    cand      = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = SEL_W'((int'(rr_q) + i) % NUM_REQ);
      if (!win_found && bus.ireq_valid[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.ireq_valid[i]) win_idx = SEL_W'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.ireq_valid) begin
          state_d = BUSY;
          sel_d   = win_idx;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
          rr_d    = (win_idx == SEL_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      BUSY: begin
        if (bus.oresp_ready && bus.oresp_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Pure pass-through mux; a dropped owner valid is forwarded as-is while responses still drain.
  always_comb begin
    bus.oreq_valid    = 1'b0;
    bus.oreq_is_write = 1'b0;
    bus.oreq_size     = '0;
    bus.oreq_addr     = '0;
    bus.oreq_strobe   = '0;
    bus.oreq_data     = '0;
    bus.oreq_len      = '0;
    bus.iresp_ready   = '0;
    bus.iresp_last    = '0;
    bus.iresp_data    = '0;
    grant             = '0;
    busy              = 1'b0;
    if (state_q == BUSY) begin
      bus.oreq_valid    = bus.ireq_valid[sel_q];
      bus.oreq_is_write = bus.ireq_is_write[sel_q];
      bus.oreq_size     = bus.ireq_size[sel_q*3 +: 3];
      bus.oreq_addr     = bus.ireq_addr[sel_q*ADDR_W +: ADDR_W];
      bus.oreq_strobe   = bus.ireq_strobe[sel_q*STRB_W +: STRB_W];
      bus.oreq_data     = bus.ireq_data[sel_q*DATA_W +: DATA_W];
      bus.oreq_len      = bus.ireq_len[sel_q*4 +: 4];
      bus.iresp_ready[sel_q]                = bus.oresp_ready;
      bus.iresp_last[sel_q]                 = bus.oresp_last;
      bus.iresp_data[sel_q*DATA_W +: DATA_W] = bus.oresp_data;
      grant[sel_q]      = 1'b1;
      busy              = 1'b1;
    end
  end
endmodule
